// File: rtl/logisim_tick_clock_gen.sv
// rtl/logisim_tick_clock_gen.sv - derived simulation clock from FPGA tick pulses
module logisim_tick_clock_gen #(
    parameter int NrOfBits  = 8,
    parameter int HighTicks = 1,
    parameter int LowTicks  = 1,
    parameter int Phase     = 1
) (
    input  logic FPGAClock,
    input  logic FPGAResetN,
    input  logic FPGATick,
    input  logic Enable,
    input  logic Step,
    output logic ClockOut,
    output logic RiseStrobe,
    output logic FallStrobe,
    output logic StepBusy
);

    typedef enum logic {
        ST_LOW  = 1'b0,
        ST_HIGH = 1'b1
    } state_t;

    localparam logic [NrOfBits-1:0] HIGH_RELOAD  = NrOfBits'(HighTicks - 1);
    localparam logic [NrOfBits-1:0] LOW_RELOAD   = NrOfBits'(LowTicks - 1);
    localparam logic [NrOfBits-1:0] PHASE_RELOAD = NrOfBits'(Phase - 1);

    state_t              state_q;
    state_t              state_d;
    logic [NrOfBits-1:0] cnt_q;
    logic [NrOfBits-1:0] cnt_d;
    logic                rise_d;
    logic                fall_d;
    logic                busy_d;
    logic                qual_tick;
    logic                forced_tick;

    // A tick counts while running or while a step is pending; a pending step
    // while halted forces the terminal-count action regardless of cnt.
    assign qual_tick   = FPGATick & (Enable | StepBusy);
    assign forced_tick = FPGATick & StepBusy & ~Enable;

    // ClockOut is taken straight from the state flop, so it is glitch-free.
    assign ClockOut = (state_q == ST_HIGH);

    // State, counter, strobe and step-latch registers.
    always_ff @(posedge FPGAClock or negedge FPGAResetN) begin
        if (!FPGAResetN) begin
            state_q    <= ST_LOW;
            cnt_q      <= PHASE_RELOAD;
            RiseStrobe <= 1'b0;
            FallStrobe <= 1'b0;
            StepBusy   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            RiseStrobe <= rise_d;
            FallStrobe <= fall_d;
            StepBusy   <= busy_d;
        end
    end

    // Next-state, reload and step-latch logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        busy_d  = StepBusy;

        // Running cancels any pending step; a step request is absorbed while
        // one is already pending, and the servicing tick wins over a new Step.
        if (Enable) begin
            busy_d = 1'b0;
        end else if (forced_tick) begin
            busy_d = 1'b0;
        end else if (Step) begin
            busy_d = 1'b1;
        end

        if (qual_tick) begin
            if ((cnt_q == '0) || forced_tick) begin
                if (state_q == ST_LOW) begin
                    state_d = ST_HIGH;
                    cnt_d   = HIGH_RELOAD;
                    rise_d  = 1'b1;
                end else begin
                    state_d = ST_LOW;
                    cnt_d   = LOW_RELOAD;
                    fall_d  = 1'b1;
                end
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

endmodule
